control_instr_issue: RTL and testbench

CONTROL_INSTR_ISSUE -- requirements
Module: control_instr_issue

---
 rtl/control_pkg.sv | 27 ++
 rtl/control_instr_issue_if.sv | 47 ++++
 rtl/control_pc_reg.sv | 41 ++++
 rtl/control_instr_issue.sv | 149 ++++++++++++++
 tb/tb_control_instr_issue.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : control_pkg                                            |
// | Description : Shared types and field constants for the instruction  |
// |               issue slice: FSM state encoding, instruction field     |
// |               bit positions and datapath widths.                     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package control_pkg;

  localparam int INSTR_W    = 16;
  localparam int PC_W       = 8;

  // Instruction field positions decoded straight off the captured word.
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 14;
  localparam int FUNCT5_BIT = 5;
  localparam int FUNCT0_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

endpackage : control_pkg
`default_nettype wire

// File: rtl/control_instr_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : control_instr_issue_if                                 |
// | Description : Bundles the instruction-memory, decoder, redirect and  |
// |               control signals of control_instr_issue.                |
// |   halt       : stop issuing after the current instruction           |
// |   imem_*     : instruction-memory request/ack/address/data          |
// |   dec_*      : decoder valid/ready handshake, instruction and PC    |
// |   op/funct*  : field slices of dec_instr                            |
// |   br_*       : redirect request and target PC                       |
// |   issue_cnt  : count of instructions accepted by the decoder        |
// |   master     : issue-block side, slave : environment side           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface control_instr_issue_if;
  import control_pkg::*;

  logic               halt;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [1:0]         op;
  logic               funct5;
  logic               funct0;
  logic [PC_W-1:0]    dec_pc;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [15:0]        issue_cnt;

  modport master (
    input  halt, imem_ack, imem_rdata, dec_ready, br_taken, br_target,
    output imem_req, imem_addr, dec_valid, dec_instr, op, funct5, funct0,
           dec_pc, issue_cnt
  );

  modport slave (
    output halt, imem_ack, imem_rdata, dec_ready, br_taken, br_target,
    input  imem_req, imem_addr, dec_valid, dec_instr, op, funct5, funct0,
           dec_pc, issue_cnt
  );

endinterface : control_instr_issue_if
`default_nettype wire

// File: rtl/control_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : control_pc_reg                                         |
// | Description : Program counter register. Load (redirect) has priority |
// |               over increment; increment wraps modulo 2**PC_W.        |
// |   clk, rst   : clock, asynchronous active-high reset                |
// |   load       : load load_val into the PC                            |
// |   load_val   : redirect target                                      |
// |   inc        : advance PC by one                                    |
// |   pc         : current PC                                           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module control_pc_reg
  import control_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            load,
  input  wire logic [PC_W-1:0] load_val,
  input  wire logic            inc,
  output logic      [PC_W-1:0] pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign pc = r_pc;

endmodule : control_pc_reg
`default_nettype wire

// File: rtl/control_instr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : control_instr_issue                                    |
// | Description : Fetches one instruction at a time from instruction     |
// |               memory and presents it to the decoder. Handles branch  |
// |               redirects in every state, halt between instructions    |
// |               and counts decoder acceptances.                        |
// |   clk, rst   : clock, asynchronous active-high reset                |
// |   bus        : control_instr_issue_if master modport (memory,       |
// |                decoder, redirect, halt and issue count)              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module control_instr_issue
  import control_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  wire logic               clk,
  input  wire logic               rst,
  control_instr_issue_if.master   bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;

  logic [1:0]         r_state;
  logic               r_redir_pend;
  logic [PC_W-1:0]    r_redir_tgt;
  logic [INSTR_W-1:0] r_dec_instr;
  logic [PC_W-1:0]    r_dec_pc;
  logic [15:0]        r_issue_cnt;

  logic [1:0]         w_state_nxt;
  logic               w_pc_load;
  logic [PC_W-1:0]    w_pc_load_val;
  logic               w_pc_inc;
  logic               w_capture;
  logic               w_accept;
  logic               w_pend_set;
  logic               w_pend_clr;
  logic [PC_W-1:0]    w_pc;

  control_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_pc_load),
    .load_val (w_pc_load_val),
    .inc      (w_pc_inc),
    .pc       (w_pc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = bus.br_target;
    w_pc_inc      = 1'b0;
    w_capture     = 1'b0;
    w_accept      = 1'b0;
    w_pend_set    = 1'b0;
    w_pend_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Memory acks arriving here belong to an abandoned request and
        // are ignored.
        if (bus.br_taken) begin
          w_pc_load = 1'b1;
        end
        if (!bus.halt) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          if (bus.br_taken) begin
            // Fresh redirect wins over both the data and any stored target.
            w_pc_load  = 1'b1;
            w_pend_clr = 1'b1;
          end else if (r_redir_pend) begin
            // Data belongs to the wrong path; re-fetch at the stored target.
            w_pc_load     = 1'b1;
            w_pc_load_val = r_redir_tgt;
            w_pend_clr    = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end else if (bus.br_taken) begin
          // Address must stay stable until the ack, so only remember the
          // target for now.
          w_pend_set = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.br_taken) begin
          w_pc_load   = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (bus.dec_ready) begin
          w_accept    = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = bus.halt ? S_IDLE : S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
      r_dec_instr  <= '0;
      r_dec_pc     <= '0;
      r_issue_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_set) begin
        r_redir_pend <= 1'b1;
        r_redir_tgt  <= bus.br_target;
      end else if (w_pend_clr) begin
        r_redir_pend <= 1'b0;
      end
      if (w_capture) begin
        r_dec_instr <= bus.imem_rdata;
        r_dec_pc    <= w_pc;
      end
      if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
    end
  end

  assign bus.imem_req  = (r_state == S_FETCH);
  assign bus.imem_addr = w_pc;
  assign bus.dec_valid = (r_state == S_ISSUE);
  assign bus.dec_instr = r_dec_instr;
  assign bus.op        = r_dec_instr[OP_MSB:OP_LSB];
  assign bus.funct5    = r_dec_instr[FUNCT5_BIT];
  assign bus.funct0    = r_dec_instr[FUNCT0_BIT];
  assign bus.dec_pc    = r_dec_pc;
  assign bus.issue_cnt = r_issue_cnt;

endmodule : control_instr_issue
`default_nettype wire

// File: tb/tb_control_instr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_control_instr_issue                                 |
// | Description : Self-checking bench for control_instr_issue. A memory  |
// |               responder with programmable ack latency feeds a        |
// |               scoreboard of expected decoder words; directed steps   |
// |               cover reset, stalls, wrap, redirects and halt.         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_control_instr_issue;

  logic clk;
  logic rst;

  control_instr_issue_if bus_if ();

  control_instr_issue #(
    .RESET_PC (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: address 0 holds the reference word, others are
  // address-derived so every fetch is distinguishable.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (a == 8'h00) return 16'h4021;
    return {a, ~a};
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_cnt;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          force_ack = 1'b0;
  bit          tb_pend   = 1'b0;
  bit          prev_wait = 1'b0;
  logic [7:0]  prev_addr;

  // Memory responder + scoreboard. Runs on the falling edge: it sets the
  // ack for the coming rising edge, then scores what the DUT will see.
  always @(negedge clk) begin
    if (force_ack) begin
      bus_if.imem_ack   = 1'b1;
      bus_if.imem_rdata = 16'hFFFF;
    end else if (rst || !bus_if.imem_req) begin
      bus_if.imem_ack = 1'b0;
      wait_cnt        = 0;
    end else if (wait_cnt >= ack_delay) begin
      bus_if.imem_ack   = 1'b1;
      bus_if.imem_rdata = mem_word(bus_if.imem_addr);
      wait_cnt          = 0;
    end else begin
      bus_if.imem_ack = 1'b0;
      wait_cnt++;
    end

    if (rst) begin
      sb_q.delete();
      exp_cnt   = 16'h0000;
      tb_pend   = 1'b0;
      prev_wait = 1'b0;
    end else begin
      check("issue_cnt", bus_if.issue_cnt, exp_cnt);
      if (bus_if.imem_req && prev_wait)
        check("addr_hold", bus_if.imem_addr, prev_addr);
      prev_wait = bus_if.imem_req && !bus_if.imem_ack;
      prev_addr = bus_if.imem_addr;

      if (bus_if.imem_req && bus_if.imem_ack) begin
        if (bus_if.br_taken || tb_pend) tb_pend = 1'b0;
        else sb_q.push_back('{instr: mem_word(bus_if.imem_addr), pc: bus_if.imem_addr});
      end else if (bus_if.imem_req && bus_if.br_taken) begin
        tb_pend = 1'b1;
      end

      if (bus_if.dec_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q[0];
          check("dec_instr", bus_if.dec_instr, e.instr);
          check("dec_pc", bus_if.dec_pc, e.pc);
          check("op", bus_if.op, e.instr[15:14]);
          check("funct5", bus_if.funct5, e.instr[5]);
          check("funct0", bus_if.funct0, e.instr[0]);
          if (bus_if.br_taken) begin
            void'(sb_q.pop_front());
          end else if (bus_if.dec_ready) begin
            void'(sb_q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic h, input logic rdy);
    rst              = 1'b1;
    bus_if.halt      = h;
    bus_if.dec_ready = rdy;
    bus_if.br_taken  = 1'b0;
    bus_if.br_target = 8'h00;
    ack_delay        = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 16'h0000;

    // Reset values and basic back-to-back issue.
    rst = 1'b1;
    bus_if.halt = 1'b0; bus_if.dec_ready = 1'b1; bus_if.br_taken = 1'b0; bus_if.br_target = 8'h00;
    tick();
    check("rst_imem_req", bus_if.imem_req, 1'b0);
    check("rst_dec_valid", bus_if.dec_valid, 1'b0);
    check("rst_imem_addr", bus_if.imem_addr, 8'h00);
    check("rst_dec_instr", bus_if.dec_instr, 16'h0000);
    check("rst_dec_pc", bus_if.dec_pc, 8'h00);
    check("rst_issue_cnt", bus_if.issue_cnt, 16'h0000);

    do_reset(1'b0, 1'b1);
    check("c1_imem_req", bus_if.imem_req, 1'b0);
    tick();
    check("c2_imem_req", bus_if.imem_req, 1'b1);
    check("c2_imem_addr", bus_if.imem_addr, 8'h00);
    tick();
    check("c3_dec_valid", bus_if.dec_valid, 1'b1);
    check("c3_op", bus_if.op, 2'b01);
    check("c3_funct5", bus_if.funct5, 1'b1);
    check("c3_funct0", bus_if.funct0, 1'b1);
    check("c3_dec_pc", bus_if.dec_pc, 8'h00);
    tick();
    check("c4_issue_cnt", bus_if.issue_cnt, 16'd1);
    check("c4_imem_addr", bus_if.imem_addr, 8'h01);
    repeat (8) tick();
    check("thru_issue_cnt", bus_if.issue_cnt, 16'd5);

    // Decoder stall: instruction and PC hold, PC advances only on accept.
    do_reset(1'b0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus_if.dec_valid, 1'b1);
      check("stall_instr", bus_if.dec_instr, 16'h4021);
      check("stall_op", bus_if.op, 2'b01);
      check("stall_dec_pc", bus_if.dec_pc, 8'h00);
      check("stall_pc", bus_if.imem_addr, 8'h00);
      tick();
    end
    bus_if.dec_ready = 1'b1;
    tick();
    check("stall_cnt", bus_if.issue_cnt, 16'd1);
    check("stall_pc_adv", bus_if.imem_addr, 8'h01);

    // Redirect in IDLE to 8'hFF, then PC wraps after one acceptance.
    do_reset(1'b1, 1'b1);
    check("idle_req", bus_if.imem_req, 1'b0);
    bus_if.br_taken = 1'b1; bus_if.br_target = 8'hFF;
    tick();
    check("idle_br_addr", bus_if.imem_addr, 8'hFF);
    check("idle_br_req", bus_if.imem_req, 1'b0);
    bus_if.br_taken = 1'b0; bus_if.halt = 1'b0;
    tick();
    tick();
    check("wrap_dec_pc", bus_if.dec_pc, 8'hFF);
    tick();
    check("wrap_addr", bus_if.imem_addr, 8'h00);
    check("wrap_cnt", bus_if.issue_cnt, 16'd1);

    // Redirect in ISSUE together with dec_ready: no count, refetch at 0x40.
    tick();
    check("iss_br_valid", bus_if.dec_valid, 1'b1);
    bus_if.br_taken = 1'b1; bus_if.br_target = 8'h40;
    tick();
    check("iss_br_cnt", bus_if.issue_cnt, 16'd1);
    check("iss_br_valid_drop", bus_if.dec_valid, 1'b0);
    check("iss_br_req", bus_if.imem_req, 1'b1);
    check("iss_br_addr", bus_if.imem_addr, 8'h40);

    // Redirects during a slow fetch: last target wins, data is dropped.
    ack_delay = 3; bus_if.br_target = 8'h30;
    tick();
    check("pend_addr1", bus_if.imem_addr, 8'h40);
    bus_if.br_target = 8'h20;
    tick();
    bus_if.br_taken = 1'b0;
    check("pend_addr2", bus_if.imem_addr, 8'h40);
    tick();
    check("pend_addr3", bus_if.imem_addr, 8'h40);
    tick();
    check("pend_new_addr", bus_if.imem_addr, 8'h20);
    check("pend_req", bus_if.imem_req, 1'b1);
    check("pend_no_valid", bus_if.dec_valid, 1'b0);
    ack_delay = 0;
    tick();
    check("pend_dec_pc", bus_if.dec_pc, 8'h20);

    // Redirect together with an ack in FETCH.
    tick();
    check("ackbr_cnt", bus_if.issue_cnt, 16'd2);
    check("ackbr_addr0", bus_if.imem_addr, 8'h21);
    bus_if.br_taken = 1'b1; bus_if.br_target = 8'h80;
    tick();
    bus_if.br_taken = 1'b0;
    check("ackbr_req", bus_if.imem_req, 1'b1);
    check("ackbr_addr", bus_if.imem_addr, 8'h80);
    check("ackbr_valid", bus_if.dec_valid, 1'b0);
    tick();
    check("ackbr_dec_pc", bus_if.dec_pc, 8'h80);

    // Halt while in ISSUE: completes, then idles until halt drops.
    bus_if.dec_ready = 1'b0; bus_if.halt = 1'b1;
    tick();
    check("halt_valid_kept", bus_if.dec_valid, 1'b1);
    bus_if.dec_ready = 1'b1;
    tick();
    check("halt_cnt", bus_if.issue_cnt, 16'd3);
    check("halt_valid", bus_if.dec_valid, 1'b0);
    check("halt_addr", bus_if.imem_addr, 8'h81);
    for (int i = 0; i < 3; i++) begin
      check("halt_req", bus_if.imem_req, 1'b0);
      tick();
    end
    bus_if.halt = 1'b0;
    tick();
    check("unhalt_req", bus_if.imem_req, 1'b1);
    check("unhalt_addr", bus_if.imem_addr, 8'h81);

    // Asynchronous reset mid-fetch, then a stray ack while IDLE.
    ack_delay = 5;
    #2 rst = 1'b1;
    #1;
    check("arst_req", bus_if.imem_req, 1'b0);
    check("arst_addr", bus_if.imem_addr, 8'h00);
    check("arst_cnt", bus_if.issue_cnt, 16'h0000);
    check("arst_dec_pc", bus_if.dec_pc, 8'h00);
    bus_if.halt = 1'b1;
    force_ack = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("stray_valid", bus_if.dec_valid, 1'b0);
    check("stray_instr", bus_if.dec_instr, 16'h0000);
    check("stray_req", bus_if.imem_req, 1'b0);
    force_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_control_instr_issue
`default_nettype wire
